// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU load/store
// unit (c_*) and an auxiliary master (a_*). One access per clock, fixed CPU
// priority, anti-starvation for aux, and a bounded bus lock for RMW sequences.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   c_req/we/lock/mode/addr/wdata     CPU request fields (held until c_gnt)
//   c_gnt, c_err                      combinational grant / out-of-range flag
//   c_rvalid, c_rdata                 registered load return (1 cycle after grant)
//   a_*                               same set for the aux master
//   m_ra/m_rm <- read port, m_rd ->   mem read port (rd is combinational from mem)
//   m_we/m_wa/m_wm/m_wd               mem write port (mem commits on negedge)
module dmem_arbiter #(
    parameter int unsigned RAM_SIZE_LOG = 8,
    parameter int unsigned STARVE_MAX   = 4,
    parameter int unsigned LOCK_MAX     = 8,
    parameter int unsigned MODE_W       = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic              c_lock,
    input  logic [MODE_W-1:0] c_mode,
    input  logic [31:0]       c_addr,
    input  logic [31:0]       c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [31:0]       c_rdata,
    output logic              c_err,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [MODE_W-1:0] a_mode,
    input  logic [31:0]       a_addr,
    input  logic [31:0]       a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [31:0]       a_rdata,
    output logic              a_err,
    output logic [31:0]       m_ra,
    output logic [MODE_W-1:0] m_rm,
    input  logic [31:0]       m_rd,
    output logic              m_we,
    output logic [31:0]       m_wa,
    output logic [MODE_W-1:0] m_wm,
    output logic [31:0]       m_wd
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned LW = $clog2(LOCK_MAX + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OWN_C = 2'd1;
    localparam logic [1:0] OWN_A = 2'd2;

    logic [1:0]    state, state_nx;
    logic [LW-1:0] lock_cnt, lock_cnt_nx;
    logic [SW-1:0] starve_cnt, starve_cnt_nx;

    logic c_oor, a_oor;
    assign c_oor = (c_addr[31:RAM_SIZE_LOG+2] != '0);
    assign a_oor = (a_addr[31:RAM_SIZE_LOG+2] != '0);

    // Grant decision: owner exclusivity first, then starvation override, then CPU priority.
    always_comb begin
        c_gnt = 1'b0;
        a_gnt = 1'b0;
        case (state)
            OWN_C:   c_gnt = c_req;
            OWN_A:   a_gnt = a_req;
            default: begin
                if (c_req && a_req) begin
                    if (starve_cnt == SW'(STARVE_MAX)) a_gnt = 1'b1;
                    else                               c_gnt = 1'b1;
                end else begin
                    c_gnt = c_req;
                    a_gnt = a_req;
                end
            end
        endcase
    end

    assign c_err = c_gnt & c_oor;
    assign a_err = a_gnt & a_oor;

    // Memory port mux; everything stays zero when nobody is granted.
    always_comb begin
        logic              g_any;
        logic              g_we;
        logic              g_oor;
        logic [MODE_W-1:0] g_mode;
        logic [31:0]       g_addr;
        logic [31:0]       g_wdata;
        g_any   = c_gnt | a_gnt;
        g_we    = c_gnt ? c_we    : (a_gnt & a_we);
        g_oor   = c_gnt ? c_oor   : (a_gnt & a_oor);
        g_mode  = c_gnt ? c_mode  : (a_gnt ? a_mode  : '0);
        g_addr  = c_gnt ? c_addr  : (a_gnt ? a_addr  : 32'h0);
        g_wdata = c_gnt ? c_wdata : (a_gnt ? a_wdata : 32'h0);
        m_ra    = (g_any && !g_we) ? g_addr  : 32'h0;
        m_rm    = g_mode;
        m_we    = g_any & g_we & ~g_oor;
        m_wa    = (g_any && g_we) ? g_addr  : 32'h0;
        m_wm    = g_mode;
        m_wd    = (g_any && g_we) ? g_wdata : 32'h0;
    end

    // Next state and counters. lock_cnt includes the grant that acquired the lock,
    // so an owner gets at most LOCK_MAX consecutive grants.
    always_comb begin
        state_nx      = state;
        lock_cnt_nx   = lock_cnt;
        starve_cnt_nx = starve_cnt;

        if (!a_req || a_gnt)                    starve_cnt_nx = '0;
        else if (starve_cnt != SW'(STARVE_MAX)) starve_cnt_nx = starve_cnt + SW'(1);

        case (state)
            IDLE: begin
                lock_cnt_nx = '0;
                if (LOCK_MAX > 32'd1) begin
                    if (c_gnt && c_lock) begin
                        state_nx    = OWN_C;
                        lock_cnt_nx = LW'(1);
                    end else if (a_gnt && a_lock) begin
                        state_nx    = OWN_A;
                        lock_cnt_nx = LW'(1);
                    end
                end
            end
            OWN_C: begin
                if (!c_req || !c_lock || lock_cnt == LW'(LOCK_MAX - 1)) begin
                    state_nx    = IDLE;
                    lock_cnt_nx = '0;
                end else begin
                    lock_cnt_nx = lock_cnt + LW'(1);
                end
            end
            OWN_A: begin
                if (!a_req || !a_lock || lock_cnt == LW'(LOCK_MAX - 1)) begin
                    state_nx    = IDLE;
                    lock_cnt_nx = '0;
                end else begin
                    lock_cnt_nx = lock_cnt + LW'(1);
                end
            end
            default: begin
                state_nx    = IDLE;
                lock_cnt_nx = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lock_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            state      <= state_nx;
            lock_cnt   <= lock_cnt_nx;
            starve_cnt <= starve_cnt_nx;
        end
    end

    // Load return path; out-of-range loads return zero instead of aliased data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rvalid <= 1'b0;
            c_rdata  <= 32'h0;
            a_rvalid <= 1'b0;
            a_rdata  <= 32'h0;
        end else begin
            c_rvalid <= c_gnt & ~c_we;
            a_rvalid <= a_gnt & ~a_we;
            if (c_gnt && !c_we) c_rdata <= c_oor ? 32'h0 : m_rd;
            if (a_gnt && !a_we) a_rdata <= a_oor ? 32'h0 : m_rd;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scenario bench for dmem_arbiter with a behavioural data memory
// (combinational read, negedge write) and per-requester load-data scoreboards.
module tb_dmem_arbiter;

    localparam int unsigned MW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          c_req, c_we, c_lock;
    logic [MW-1:0] c_mode;
    logic [31:0]   c_addr, c_wdata;
    logic          c_gnt, c_rvalid, c_err;
    logic [31:0]   c_rdata;
    logic          a_req, a_we, a_lock;
    logic [MW-1:0] a_mode;
    logic [31:0]   a_addr, a_wdata;
    logic          a_gnt, a_rvalid, a_err;
    logic [31:0]   a_rdata;
    logic [31:0]   m_ra, m_rd, m_wa, m_wd;
    logic [MW-1:0] m_rm, m_wm;
    logic          m_we;

    logic [31:0]   dmem [256];
    logic          preload = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] cq[$];
    logic [31:0] aq[$];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_mode(c_mode),
        .c_addr(c_addr), .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
        .c_rdata(c_rdata), .c_err(c_err),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_mode(a_mode),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
        .a_rdata(a_rdata), .a_err(a_err),
        .m_ra(m_ra), .m_rm(m_rm), .m_rd(m_rd), .m_we(m_we),
        .m_wa(m_wa), .m_wm(m_wm), .m_wd(m_wd)
    );

    // Data memory model: writes land on the negedge of the grant cycle.
    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) dmem[i] <= 32'hA500_0000 | 32'(i);
        end else if (m_we) begin
            dmem[m_wa[9:2]] <= m_wd;
        end
    end
    assign m_rd = dmem[m_ra[9:2]];

    function automatic logic [31:0] init_word(input int unsigned idx);
        return 32'hA500_0000 | idx;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c_req = 1'b0; c_we = 1'b0; c_lock = 1'b0; c_mode = '0; c_addr = 32'h0; c_wdata = 32'h0;
        a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_mode = '0; a_addr = 32'h0; a_wdata = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n   = 1'b0;
        preload = 1'b1;
        repeat (2) @(negedge clk);
        preload = 1'b0;
        #2;
        checks++;
        if ({c_rvalid, a_rvalid, c_gnt, a_gnt, m_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b exp 00000", {c_rvalid, a_rvalid, c_gnt, a_gnt, m_we});
        end
        checks++;
        if ({c_rdata, a_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got c=%h a=%h exp 0", c_rdata, a_rdata);
        end
        checks++;
        if ({m_ra, m_wa, m_wd} !== 96'h0) begin
            errors++;
            $display("FAIL reset_mbus: got ra=%h wa=%h wd=%h exp 0", m_ra, m_wa, m_wd);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_cpu_load();
        logic [31:0] exp;
        tick();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_mode = 3'd2;
        #2;
        checks++;
        if ({c_gnt, a_gnt, c_err} !== 3'b100) begin
            errors++;
            $display("FAIL load_gnt: got c_gnt,a_gnt,c_err=%b exp 100", {c_gnt, a_gnt, c_err});
        end
        checks++;
        if (m_ra !== 32'h10 || m_we !== 1'b0 || m_rm !== 3'd2) begin
            errors++;
            $display("FAIL load_mbus: got ra=%h we=%b rm=%0d exp ra=10 we=0 rm=2", m_ra, m_we, m_rm);
        end
        cq.push_back(init_word(4));
        tick();
        c_req = 1'b0;
        #2;
        checks++;
        if ({c_rvalid, a_rvalid} !== 2'b10) begin
            errors++;
            $display("FAIL load_rvalid: got c,a=%b exp 10", {c_rvalid, a_rvalid});
        end
        exp = cq.pop_front();
        checks++;
        if (c_rdata !== exp) begin
            errors++;
            $display("FAIL load_rdata: got %h exp %h", c_rdata, exp);
        end
        tick();
        #2;
        checks++;
        if (c_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL load_rvalid_pulse: got %b exp 0", c_rvalid);
        end
    endtask

    task automatic test_starvation();
        logic [1:0]  exp_g [6];
        logic [1:0]  prev;
        logic [31:0] exp;
        exp_g = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        prev  = 2'b00;
        for (int i = 0; i <= 6; i++) begin
            tick();
            if (i < 6) begin
                c_req = 1'b1; c_we = 1'b0; c_lock = 1'b0; c_addr = 32'h40;
                a_req = 1'b1; a_we = 1'b0; a_lock = 1'b0; a_addr = 32'h44;
            end else begin
                idle_inputs();
            end
            #2;
            checks++;
            if ({c_rvalid, a_rvalid} !== prev) begin
                errors++;
                $display("FAIL starve_rvalid[%0d]: got %b exp %b", i, {c_rvalid, a_rvalid}, prev);
            end
            if (prev[1]) begin
                exp = cq.pop_front();
                checks++;
                if (c_rdata !== exp) begin
                    errors++;
                    $display("FAIL starve_c_rdata[%0d]: got %h exp %h", i, c_rdata, exp);
                end
            end
            if (prev[0]) begin
                exp = aq.pop_front();
                checks++;
                if (a_rdata !== exp) begin
                    errors++;
                    $display("FAIL starve_a_rdata[%0d]: got %h exp %h", i, a_rdata, exp);
                end
            end
            if (i < 6) begin
                checks++;
                if ({c_gnt, a_gnt} !== exp_g[i]) begin
                    errors++;
                    $display("FAIL starve_gnt[%0d]: got %b exp %b", i, {c_gnt, a_gnt}, exp_g[i]);
                end
                prev = exp_g[i];
                if (prev[1]) cq.push_back(init_word(16));
                if (prev[0]) aq.push_back(init_word(17));
            end
        end
    endtask

    task automatic test_stdout();
        logic [31:0] exp;
        tick();
        a_req = 1'b1; a_we = 1'b1; a_lock = 1'b0; a_addr = 32'hFC; a_wdata = 32'h1234_5678;
        #2;
        checks++;
        if ({c_gnt, a_gnt, a_err} !== 3'b010) begin
            errors++;
            $display("FAIL stdout_gnt: got c_gnt,a_gnt,a_err=%b exp 010", {c_gnt, a_gnt, a_err});
        end
        checks++;
        if (m_we !== 1'b1 || m_wa !== 32'hFC || m_wd !== 32'h1234_5678) begin
            errors++;
            $display("FAIL stdout_mbus: got we=%b wa=%h wd=%h exp 1 fc 12345678", m_we, m_wa, m_wd);
        end
        tick();
        idle_inputs();
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'hFC;
        #2;
        checks++;
        if (dmem[63][23:0] !== 24'h345678) begin
            errors++;
            $display("FAIL stdout_hex: got %h exp 345678", dmem[63][23:0]);
        end
        checks++;
        if (c_gnt !== 1'b1) begin
            errors++;
            $display("FAIL stdout_readback_gnt: got %b exp 1", c_gnt);
        end
        cq.push_back(32'h1234_5678);
        tick();
        idle_inputs();
        #2;
        exp = cq.pop_front();
        checks++;
        if (c_rvalid !== 1'b1 || c_rdata !== exp) begin
            errors++;
            $display("FAIL stdout_readback: got v=%b d=%h exp v=1 d=%h", c_rvalid, c_rdata, exp);
        end
    endtask

    task automatic test_lock();
        logic [31:0] exp;
        // Locked load then store (RMW); aux must not slip in between.
        tick();
        c_req = 1'b1; c_we = 1'b0; c_lock = 1'b1; c_addr = 32'h20;
        a_req = 1'b1; a_we = 1'b0; a_lock = 1'b0; a_addr = 32'h20;
        #2;
        checks++;
        if ({c_gnt, a_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL lock_rd_gnt: got %b exp 10", {c_gnt, a_gnt});
        end
        cq.push_back(init_word(8));
        tick();
        c_we = 1'b1; c_lock = 1'b0; c_wdata = 32'hDEAD_BEEF;
        #2;
        checks++;
        if ({c_gnt, a_gnt, m_we} !== 3'b101) begin
            errors++;
            $display("FAIL lock_wr_gnt: got c_gnt,a_gnt,m_we=%b exp 101", {c_gnt, a_gnt, m_we});
        end
        exp = cq.pop_front();
        checks++;
        if (c_rvalid !== 1'b1 || c_rdata !== exp) begin
            errors++;
            $display("FAIL lock_rd_data: got v=%b d=%h exp v=1 d=%h", c_rvalid, c_rdata, exp);
        end
        tick();
        c_req = 1'b0; c_we = 1'b0;
        #2;
        checks++;
        if ({c_gnt, a_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL lock_release_gnt: got %b exp 01", {c_gnt, a_gnt});
        end
        aq.push_back(32'hDEAD_BEEF);
        tick();
        idle_inputs();
        #2;
        exp = aq.pop_front();
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== exp) begin
            errors++;
            $display("FAIL lock_aux_data: got v=%b d=%h exp v=1 d=%h", a_rvalid, a_rdata, exp);
        end
        // Owner idles while holding the lock: aux still waits that cycle.
        tick();
        c_req = 1'b1; c_we = 1'b0; c_lock = 1'b1; c_addr = 32'h30;
        a_req = 1'b1; a_we = 1'b0; a_lock = 1'b0; a_addr = 32'h34;
        #2;
        checks++;
        if ({c_gnt, a_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL lock2_gnt: got %b exp 10", {c_gnt, a_gnt});
        end
        cq.push_back(init_word(12));
        tick();
        c_req = 1'b0; c_lock = 1'b0;
        #2;
        checks++;
        if ({c_gnt, a_gnt} !== 2'b00) begin
            errors++;
            $display("FAIL lock2_hold: got %b exp 00", {c_gnt, a_gnt});
        end
        exp = cq.pop_front();
        checks++;
        if (c_rvalid !== 1'b1 || c_rdata !== exp) begin
            errors++;
            $display("FAIL lock2_rd: got v=%b d=%h exp v=1 d=%h", c_rvalid, c_rdata, exp);
        end
        tick();
        #2;
        checks++;
        if ({c_gnt, a_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL lock2_aux_gnt: got %b exp 01", {c_gnt, a_gnt});
        end
        aq.push_back(init_word(13));
        tick();
        idle_inputs();
        #2;
        exp = aq.pop_front();
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== exp) begin
            errors++;
            $display("FAIL lock2_aux_data: got v=%b d=%h exp v=1 d=%h", a_rvalid, a_rdata, exp);
        end
    endtask

    task automatic test_lock_timeout();
        logic [1:0]  exp_g [10];
        logic [1:0]  prev;
        logic [31:0] exp;
        exp_g = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
        prev  = 2'b00;
        for (int i = 0; i <= 11; i++) begin
            tick();
            if (i < 10) begin
                c_req = 1'b1; c_we = 1'b0; c_lock = 1'b1; c_addr = 32'h50;
                a_req = 1'b1; a_we = 1'b0; a_lock = 1'b0; a_addr = 32'h54;
            end else begin
                idle_inputs();
            end
            #2;
            checks++;
            if ({c_rvalid, a_rvalid} !== prev) begin
                errors++;
                $display("FAIL lockmax_rvalid[%0d]: got %b exp %b", i, {c_rvalid, a_rvalid}, prev);
            end
            if (prev[1]) begin
                exp = cq.pop_front();
                checks++;
                if (c_rdata !== exp) begin
                    errors++;
                    $display("FAIL lockmax_c_rdata[%0d]: got %h exp %h", i, c_rdata, exp);
                end
            end
            if (prev[0]) begin
                exp = aq.pop_front();
                checks++;
                if (a_rdata !== exp) begin
                    errors++;
                    $display("FAIL lockmax_a_rdata[%0d]: got %h exp %h", i, a_rdata, exp);
                end
            end
            prev = 2'b00;
            if (i < 10) begin
                checks++;
                if ({c_gnt, a_gnt} !== exp_g[i]) begin
                    errors++;
                    $display("FAIL lockmax_gnt[%0d]: got %b exp %b", i, {c_gnt, a_gnt}, exp_g[i]);
                end
                prev = exp_g[i];
                if (prev[1]) cq.push_back(init_word(20));
                if (prev[0]) aq.push_back(init_word(21));
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] exp;
        tick();
        a_req = 1'b1; a_we = 1'b1; a_lock = 1'b0; a_addr = 32'h400; a_wdata = 32'hBADB_AD00;
        #2;
        checks++;
        if ({a_gnt, a_err, m_we} !== 3'b110) begin
            errors++;
            $display("FAIL oor_store: got a_gnt,a_err,m_we=%b exp 110", {a_gnt, a_err, m_we});
        end
        tick();
        a_we = 1'b0;
        #2;
        checks++;
        if ({a_gnt, a_err} !== 2'b11) begin
            errors++;
            $display("FAIL oor_load: got a_gnt,a_err=%b exp 11", {a_gnt, a_err});
        end
        checks++;
        if (dmem[0] !== init_word(0)) begin
            errors++;
            $display("FAIL oor_dmem: got %h exp %h", dmem[0], init_word(0));
        end
        aq.push_back(32'h0);
        tick();
        idle_inputs();
        #2;
        exp = aq.pop_front();
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== exp) begin
            errors++;
            $display("FAIL oor_rdata: got v=%b d=%h exp v=1 d=%h", a_rvalid, a_rdata, exp);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        tick();
        c_req = 1'b1; c_we = 1'b0; c_lock = 1'b1; c_addr = 32'h10;
        #2;
        checks++;
        if (c_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_gnt: got %b exp 1", c_gnt);
        end
        #1;
        rst_n = 1'b0;
        idle_inputs();
        tick();
        #2;
        checks++;
        if (c_rvalid !== 1'b0 || c_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_rvalid: got v=%b d=%h exp v=0 d=0", c_rvalid, c_rdata);
        end
        rst_n = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h18;
        #1;
        checks++;
        if ({c_gnt, a_gnt} !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_lock_cleared: got %b exp 01", {c_gnt, a_gnt});
        end
        aq.push_back(init_word(6));
        tick();
        idle_inputs();
        #2;
        exp = aq.pop_front();
        checks++;
        if (a_rvalid !== 1'b1 || a_rdata !== exp) begin
            errors++;
            $display("FAIL rstmid_aux_data: got v=%b d=%h exp v=1 d=%h", a_rvalid, a_rdata, exp);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_load();
        test_starvation();
        test_stdout();
        test_lock();
        test_lock_timeout();
        test_out_of_range();
        test_reset_mid();
        checks++;
        if (cq.size() != 0 || aq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got c=%0d a=%0d pending exp 0", cq.size(), aq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
